memory_ctrl: RTL and testbench

Parametrised single-port memory with a request/acknowledge handshake, programmable wait states, and a hardware clear sequencer. It replaces the bidirectional data bus with separate write and read buses. It clears the array one word per cycle instead of in zero time. It sits between the CPU data-register path and on-chip storage, and is addressed by the same address/read_write convention (read_write high = read).

---
 rtl/memory_ctrl_pkg.sv | 20 ++
 rtl/memory_ctrl_array.sv | 32 +++
 rtl/memory_ctrl.sv | 152 +++++++++++++++
 tb/tb_memory_ctrl.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/memory_ctrl_pkg.sv
// memory_ctrl_pkg
// Shared constants for the memory controller: FSM state encoding, the
// read_write bus encoding and the width of the wait-state counter.
// No ports (package).
package memory_ctrl_pkg;

  // FSM state encoding (kept as plain constants for legacy compatibility)
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_WAIT   = 2'd1;
  localparam logic [1:0] ST_ACCESS = 2'd2;
  localparam logic [1:0] ST_CLEAR  = 2'd3;

  // read_write encoding shared with the CPU data-register path
  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // Wait counter width; holds WAIT_STATES-1 for WAIT_STATES in 0..15
  localparam int WAIT_CNT_W = 4;

endpackage

// File: rtl/memory_ctrl_array.sv
// memory_array
// Single-port synchronous RAM with registered write and registered read.
// Contents are never reset; the controller's clear sequence zeroes them.
// Ports:
//   clk    - clock, write and read register on rising edge
//   we     - write enable
//   addr   - word address
//   wdata  - write data
//   rdata  - registered read data (old contents on a same-address write)
module memory_array #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
    rdata <= mem[addr];
  end

endmodule

// File: rtl/memory_ctrl.sv
// memory_ctrl
// Request/acknowledge front end for a single-port memory with programmable
// wait states and a one-word-per-cycle hardware clear sequencer.
// Ports:
//   clk        - clock, all state updates on rising edge
//   reset      - asynchronous active-high reset
//   req        - access request, sampled only in IDLE
//   read_write - 1 = read, 0 = write; sampled with req
//   address    - word address; sampled with req
//   wdata      - write data; sampled with req
//   clear      - start a clear of the whole array; sampled only in IDLE
//   rdata      - read data, valid with ack of a read, held until next read ack
//   ack        - one-cycle pulse marking transaction completion
//   busy       - high whenever the controller is not in IDLE
module memory_ctrl
  import memory_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH     = 16,
  parameter int ADDR_WIDTH     = 8,
  parameter int WAIT_STATES    = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  read_write,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  clear,
  output logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack,
  output logic                  busy
);

  generate
    if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
      $error("memory_ctrl: WAIT_STATES must be in 0..15");
    end
  endgenerate

  localparam logic [1:0] RESET_STATE = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
  localparam logic [WAIT_CNT_W-1:0] WAIT_INIT =
      (WAIT_STATES > 0) ? WAIT_CNT_W'(WAIT_STATES - 1) : '0;
  // clr_ptr carries one extra bit so the terminal value never aliases address 0
  localparam logic [ADDR_WIDTH:0] CLR_LAST = (ADDR_WIDTH + 1)'((1 << ADDR_WIDTH) - 1);

  logic [1:0]            state_reg;
  logic [WAIT_CNT_W-1:0] wait_cnt_reg;
  logic [ADDR_WIDTH:0]   clr_ptr_reg;
  logic                  rw_reg;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] wdata_reg;
  logic                  ack_reg;
  logic                  rd_ack_reg;
  logic [DATA_WIDTH-1:0] rdata_hold_reg;

  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [DATA_WIDTH-1:0] mem_rdata;

  // The clear sequencer owns the array port while in CLEAR; otherwise the
  // latched transaction drives it. Writes only happen in the ACCESS cycle.
  always_comb begin
    mem_we    = 1'b0;
    mem_addr  = addr_reg;
    mem_wdata = wdata_reg;
    if (state_reg == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_addr  = clr_ptr_reg[ADDR_WIDTH-1:0];
      mem_wdata = '0;
    end else if (state_reg == ST_ACCESS && rw_reg == RW_WRITE) begin
      mem_we = 1'b1;
    end
  end

  memory_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_array (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(mem_wdata),
    .rdata(mem_rdata)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg      <= RESET_STATE;
      wait_cnt_reg   <= '0;
      clr_ptr_reg    <= '0;
      rw_reg         <= RW_WRITE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      ack_reg        <= 1'b0;
      rd_ack_reg     <= 1'b0;
      rdata_hold_reg <= '0;
    end else begin
      ack_reg    <= 1'b0;
      rd_ack_reg <= 1'b0;
      // The array re-reads every cycle, so capture the word seen with a
      // read ack and present it until the next read completes.
      if (rd_ack_reg) begin
        rdata_hold_reg <= mem_rdata;
      end
      case (state_reg)
        ST_IDLE: begin
          if (clear) begin
            state_reg   <= ST_CLEAR;
            clr_ptr_reg <= '0;
          end else if (req) begin
            rw_reg    <= read_write;
            addr_reg  <= address;
            wdata_reg <= wdata;
            if (WAIT_STATES == 0) begin
              state_reg <= ST_ACCESS;
            end else begin
              state_reg    <= ST_WAIT;
              wait_cnt_reg <= WAIT_INIT;
            end
          end
        end
        ST_WAIT: begin
          if (wait_cnt_reg == '0) begin
            state_reg <= ST_ACCESS;
          end else begin
            wait_cnt_reg <= wait_cnt_reg - 1'b1;
          end
        end
        ST_ACCESS: begin
          // ack and the array's read register update on the same edge,
          // so rdata is valid exactly while ack is high
          ack_reg    <= 1'b1;
          rd_ack_reg <= (rw_reg == RW_READ);
          state_reg  <= ST_IDLE;
        end
        default: begin
          clr_ptr_reg <= clr_ptr_reg + 1'b1;
          if (clr_ptr_reg == CLR_LAST) begin
            state_reg <= ST_IDLE;
          end
        end
      endcase
    end
  end

  assign rdata = rd_ack_reg ? mem_rdata : rdata_hold_reg;
  assign ack   = ack_reg;
  assign busy  = (state_reg != ST_IDLE);

endmodule

// File: tb/tb_memory_ctrl.sv
// tb_memory_ctrl
// Directed bench driving two controllers (WAIT_STATES=1 at index 1,
// WAIT_STATES=0 at index 0), both 16 words deep with clear-on-reset.
module tb_memory_ctrl;
  import memory_ctrl_pkg::*;

  logic             clk = 1'b0;
  logic [1:0]       rst_v;
  logic [1:0]       req_v;
  logic [1:0]       rw_v;
  logic [1:0]       clear_v;
  logic [1:0][3:0]  addr_v;
  logic [1:0][15:0] wdata_v;
  logic [1:0][15:0] rdata_v;
  logic [1:0]       ack_v;
  logic [1:0]       busy_v;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WAIT_STATES(1), .CLEAR_ON_RESET(1)) dut_ws1 (
    .clk(clk), .reset(rst_v[1]), .req(req_v[1]), .read_write(rw_v[1]),
    .address(addr_v[1]), .wdata(wdata_v[1]), .clear(clear_v[1]),
    .rdata(rdata_v[1]), .ack(ack_v[1]), .busy(busy_v[1])
  );

  memory_ctrl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .WAIT_STATES(0), .CLEAR_ON_RESET(1)) dut_ws0 (
    .clk(clk), .reset(rst_v[0]), .req(req_v[0]), .read_write(rw_v[0]),
    .address(addr_v[0]), .wdata(wdata_v[0]), .clear(clear_v[0]),
    .rdata(rdata_v[0]), .ack(ack_v[0]), .busy(busy_v[0])
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One full transaction; inputs are scrambled right after sampling.
  task automatic do_access(input int sel, input logic rw, input logic [3:0] a,
                           input logic [15:0] d, input logic [15:0] exp_rd,
                           input int exp_lat, input string tag);
    int lat;
    @(negedge clk);
    req_v[sel] = 1'b1; rw_v[sel] = rw; addr_v[sel] = a; wdata_v[sel] = d;
    @(posedge clk); #1;
    req_v[sel] = 1'b0; wdata_v[sel] = 16'hFFFF; addr_v[sel] = ~a;
    lat = 0;
    while (ack_v[sel] !== 1'b1 && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk({tag, "_lat"}, lat, exp_lat);
    if (rw == RW_READ) chk({tag, "_rdata"}, rdata_v[sel], exp_rd);
    $display("txn dut%0d %s addr=0x%0h data=0x%0h lat=%0d", sel,
             (rw == RW_READ) ? "rd" : "wr", a, (rw == RW_READ) ? rdata_v[sel] : d, lat);
    @(posedge clk); #1;
    chk({tag, "_ackpulse"}, ack_v[sel], 1'b0);
    if (rw == RW_READ) chk({tag, "_hold"}, rdata_v[sel], exp_rd);
  endtask

  // Counts busy cycles (sampled on falling edges) and acks until idle.
  task automatic count_busy(input int sel, output int n, output int acks);
    n = 0; acks = 0;
    while (busy_v[sel] === 1'b1 && n < 100) begin
      if (ack_v[sel] === 1'b1) acks++;
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, acks, w, s, n1, n0, cyc;
    rst_v = 2'b11; req_v = '0; rw_v = '0; clear_v = '0; addr_v = '0; wdata_v = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_ack%0d", i), ack_v[i], 1'b0);
      chk($sformatf("rst_rdata%0d", i), rdata_v[i], 16'h0000);
      chk($sformatf("rst_busy%0d", i), busy_v[i], 1'b1);
    end

    // Post-reset clear: both controllers stay busy for exactly 16 cycles
    rst_v = 2'b00;
    n1 = 0; n0 = 0; cyc = 0;
    while (busy_v != 2'b00 && cyc < 100) begin
      n1 += int'(busy_v[1]);
      n0 += int'(busy_v[0]);
      cyc++;
      @(negedge clk);
    end
    chk("rstclr_busy1", n1, 16);
    chk("rstclr_busy0", n0, 16);
    $display("txn reset clear busy cycles dut1=%0d dut0=%0d", n1, n0);

    for (int a = 0; a < 16; a++)
      do_access(1, RW_READ, 4'(a), 16'h0, 16'h0000, 2, $sformatf("init_rd%0d", a));

    // WAIT_STATES=1 write then read
    do_access(1, RW_WRITE, 4'h3, 16'hBEEF, 16'h0, 2, "ws1_wr3");
    do_access(1, RW_READ,  4'h3, 16'h0, 16'hBEEF, 2, "ws1_rd3");

    // Back-to-back reads with req held: ack spacing is WAIT_STATES+2
    @(negedge clk);
    req_v[1] = 1'b1; rw_v[1] = RW_READ; addr_v[1] = 4'h3;
    w = 0;
    do begin @(posedge clk); #1; w++; end while (ack_v[1] !== 1'b1 && w < 20);
    chk("b2b_first_lat", w, 3);
    s = 0;
    do begin @(posedge clk); #1; s++; end while (ack_v[1] !== 1'b1 && s < 20);
    req_v[1] = 1'b0;
    chk("b2b_spacing", s, 3);
    chk("b2b_rdata", rdata_v[1], 16'hBEEF);
    $display("txn dut1 b2b reads spacing=%0d", s);
    @(posedge clk); #1;
    chk("b2b_ackdrop", ack_v[1], 1'b0);

    // WAIT_STATES=0 write then immediate read; wdata scrambled after sampling
    do_access(0, RW_WRITE, 4'hF, 16'h1234, 16'h0, 1, "ws0_wrF");
    do_access(0, RW_READ,  4'hF, 16'h0, 16'h1234, 1, "ws0_rdF");

    // clear and req together: clear wins, req dropped
    @(negedge clk);
    clear_v[1] = 1'b1; req_v[1] = 1'b1; rw_v[1] = RW_WRITE; addr_v[1] = 4'h3; wdata_v[1] = 16'hAAAA;
    @(posedge clk); #1;
    clear_v[1] = 1'b0; req_v[1] = 1'b0;
    @(negedge clk);
    count_busy(1, n, acks);
    chk("clrreq_busy", n, 16);
    chk("clrreq_acks", acks, 0);
    $display("txn dut1 clear+req busy=%0d acks=%0d", n, acks);
    do_access(1, RW_READ, 4'h3, 16'h0, 16'h0000, 2, "clr_rd3");

    // req pulsed during WAIT is ignored
    @(negedge clk);
    req_v[1] = 1'b1; rw_v[1] = RW_WRITE; addr_v[1] = 4'h7; wdata_v[1] = 16'h1111;
    @(posedge clk); #1;
    addr_v[1] = 4'h8; wdata_v[1] = 16'h2222;
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    chk("waitreq_noack_early", ack_v[1], 1'b0);
    @(posedge clk); #1;
    chk("waitreq_ack", ack_v[1], 1'b1);
    acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_v[1] === 1'b1) acks++;
    end
    chk("waitreq_extra_acks", acks, 0);
    $display("txn dut1 wr addr=0x7 with req during WAIT extra_acks=%0d", acks);
    do_access(1, RW_READ, 4'h7, 16'h0, 16'h1111, 2, "waitreq_rd7");
    do_access(1, RW_READ, 4'h8, 16'h0, 16'h0000, 2, "waitreq_rd8");

    // req pulsed during CLEAR is ignored
    @(negedge clk);
    clear_v[0] = 1'b1;
    @(posedge clk); #1;
    clear_v[0] = 1'b0;
    @(negedge clk);
    n = 0; acks = 0;
    while (busy_v[0] === 1'b1 && n < 100) begin
      if (n == 3) begin
        req_v[0] = 1'b1; rw_v[0] = RW_WRITE; addr_v[0] = 4'h9; wdata_v[0] = 16'h5555;
      end
      if (n == 6) req_v[0] = 1'b0;
      if (ack_v[0] === 1'b1) acks++;
      n++;
      @(negedge clk);
    end
    req_v[0] = 1'b0;
    chk("clrbusy_busy", n, 16);
    chk("clrbusy_acks", acks, 0);
    $display("txn dut0 clear with req pulse busy=%0d acks=%0d", n, acks);
    do_access(0, RW_READ, 4'h9, 16'h0, 16'h0000, 1, "clrbusy_rd9");
    do_access(0, RW_READ, 4'hF, 16'h0, 16'h0000, 1, "clrbusy_rdF");

    // Reset during WAIT of a write to 0x5
    do_access(1, RW_WRITE, 4'h5, 16'h1357, 16'h0, 2, "pre_wr5");
    do_access(1, RW_READ,  4'h5, 16'h0, 16'h1357, 2, "pre_rd5");
    @(negedge clk);
    req_v[1] = 1'b1; rw_v[1] = RW_WRITE; addr_v[1] = 4'h5; wdata_v[1] = 16'h5A5A;
    @(posedge clk); #1;
    req_v[1] = 1'b0;
    rst_v[1] = 1'b1;
    #1;
    chk("midrst_ack", ack_v[1], 1'b0);
    chk("midrst_rdata", rdata_v[1], 16'h0000);
    chk("midrst_busy", busy_v[1], 1'b1);
    @(negedge clk);
    @(negedge clk);
    rst_v[1] = 1'b0;
    count_busy(1, n, acks);
    chk("midrst_clr_busy", n, 16);
    chk("midrst_clr_acks", acks, 0);
    $display("txn dut1 reset during WAIT busy=%0d acks=%0d", n, acks);
    do_access(1, RW_READ, 4'h5, 16'h0, 16'h0000, 2, "midrst_rd5");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
